// File: rtl/lcdi_stream_gen2_if.sv
// Pixel-stream bundle between the LCDI frame-timing generator and its source/sink.
// The block itself uses the slave view; the surrounding source/packer uses master.
interface lcdi_stream_gen2_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 3
);
  logic                         frame_start;
  logic [1:0]                   mode;
  logic [NUM_CH*DATA_WIDTH-1:0] data_in;
  logic                         data_in_valid;
  logic [NUM_CH*DATA_WIDTH-1:0] data_out;
  logic                         data_out_valid;
  logic                         line_end;
  logic                         frame_end;
  logic                         busy;

  modport master (
    output frame_start, mode, data_in,
    input  data_in_valid, data_out, data_out_valid, line_end, frame_end, busy
  );

  modport slave (
    input  frame_start, mode, data_in,
    output data_in_valid, data_out, data_out_valid, line_end, frame_end, busy
  );
endinterface

// File: rtl/lcdi_stream_gen2.sv
// LCDI line/column stream generator: frame timing, 2-stage pixel pipeline with
// passthrough, horizontal 2-tap average or channel-adjacent average modes.
module lcdi_stream_gen2 #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned IMG_W      = 640,
  parameter int unsigned IMG_H      = 480,
  parameter int unsigned H_BLANK    = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  lcdi_stream_gen2_if.slave   bus
);

  localparam int unsigned DW       = DATA_WIDTH;
  localparam int unsigned PW       = NUM_CH * DW;
  localparam int unsigned COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned HB_W     = (H_BLANK > 1) ? $clog2(H_BLANK) : 1;
  localparam int unsigned HB_LAST  = (H_BLANK > 0) ? H_BLANK - 1 : 0;
  localparam int unsigned LAST_COL = IMG_W - 1;
  localparam int unsigned LAST_ROW = IMG_H - 1;

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, FLUSH} state_t;

  state_t            state;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [HB_W-1:0]   hb_cnt;
  logic              fl_cnt;
  logic [1:0]        mode_q;
  logic              fetch;
  logic              busy_q;

  logic              s1_valid;
  logic [PW-1:0]     s1_data;
  logic              s1_first;
  logic              s1_last_col;
  logic              s1_last_row;

  logic [PW-1:0]     prev;
  logic [PW-1:0]     proc;
  logic [PW+DW-1:0]  ext;
  logic [PW-1:0]     data_out_q;
  logic              out_valid;
  logic              line_end_q;
  logic              frame_end_q;

  function automatic logic [DW-1:0] avg(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b} + (DW+1)'(1);
    return s[DW:1];
  endfunction

  // Frame timing: fetch strobe, line/row counters, blanking and drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      col    <= '0;
      row    <= '0;
      hb_cnt <= '0;
      fl_cnt <= 1'b0;
      mode_q <= 2'd0;
      fetch  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.frame_start) begin
            state  <= ACTIVE;
            mode_q <= bus.mode;
            col    <= '0;
            row    <= '0;
            fetch  <= 1'b1;
            busy_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (col == COL_W'(LAST_COL)) begin
            col <= '0;
            if (row == ROW_W'(LAST_ROW)) begin
              state  <= FLUSH;
              fetch  <= 1'b0;
              fl_cnt <= 1'b0;
            end else begin
              row <= row + ROW_W'(1);
              if (H_BLANK != 0) begin
                state  <= HBLANK;
                fetch  <= 1'b0;
                hb_cnt <= '0;
              end
            end
          end else begin
            col <= col + COL_W'(1);
          end
        end
        HBLANK: begin
          if (hb_cnt == HB_W'(HB_LAST)) begin
            state <= ACTIVE;
            fetch <= 1'b1;
          end else begin
            hb_cnt <= hb_cnt + HB_W'(1);
          end
        end
        FLUSH: begin
          // Two drain cycles cover the pipeline; busy drops right after frame_end.
          if (fl_cnt) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            fl_cnt <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 1: capture the fetched pixel with its position flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_data     <= '0;
      s1_first    <= 1'b0;
      s1_last_col <= 1'b0;
      s1_last_row <= 1'b0;
    end else begin
      s1_valid <= fetch;
      if (fetch) begin
        s1_data     <= bus.data_in;
        s1_first    <= (col == '0);
        s1_last_col <= (col == COL_W'(LAST_COL));
        s1_last_row <= (row == ROW_W'(LAST_ROW));
      end
    end
  end

  // Duplicating the top channel makes its self-average an identity.
  assign ext = {s1_data[PW-1 -: DW], s1_data};

  always_comb begin
    proc = s1_data;
    for (int k = 0; k < int'(NUM_CH); k++) begin
      case (mode_q)
        2'd1: begin
          if (!s1_first) proc[k*DW +: DW] = avg(prev[k*DW +: DW], s1_data[k*DW +: DW]);
        end
        2'd2: proc[k*DW +: DW] = avg(ext[k*DW +: DW], ext[(k+1)*DW +: DW]);
        default: ;
      endcase
    end
  end

  // Stage 2: registered result and markers; prev is cleared at each line end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev        <= '0;
      data_out_q  <= '0;
      out_valid   <= 1'b0;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      out_valid   <= s1_valid;
      line_end_q  <= s1_valid & s1_last_col;
      frame_end_q <= s1_valid & s1_last_col & s1_last_row;
      if (s1_valid) begin
        data_out_q <= proc;
        prev       <= s1_last_col ? '0 : s1_data;
      end
    end
  end

  assign bus.data_in_valid  = fetch;
  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = out_valid;
  assign bus.line_end       = line_end_q;
  assign bus.frame_end      = frame_end_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_lcdi_stream_gen2.sv
// Scoreboard bench for lcdi_stream_gen2: directed frames push expected pixels,
// a negedge monitor pops and compares them as the DUTs emit output.
module tb_lcdi_stream_gen2;

  localparam int DW   = 8;
  localparam int NC   = 3;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int HB   = 2;
  localparam int PW   = DW * NC;
  localparam int NPIX = W * H;
  localparam int WIN  = 14;

  typedef struct packed {
    logic [PW-1:0] data;
    logic          le;
    logic          fe;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lcdi_stream_gen2_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus_a ();
  lcdi_stream_gen2_if #(.DATA_WIDTH(DW), .NUM_CH(NC)) bus_b ();

  lcdi_stream_gen2 #(.DATA_WIDTH(DW), .NUM_CH(NC), .IMG_W(W), .IMG_H(H), .H_BLANK(HB))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  lcdi_stream_gen2 #(.DATA_WIDTH(DW), .NUM_CH(NC), .IMG_W(W), .IMG_H(H), .H_BLANK(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  logic [PW-1:0] src_pix [NPIX];
  logic [2:0]    src_idx_a, src_idx_b;
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            frames_a = 0;
  int            frames_b = 0;
  exp_t          exp_qa [$];
  exp_t          exp_qb [$];
  int            fq_a [$];
  int            fq_b [$];

  logic [PW-1:0] t_ch [NPIX];
  logic [PW-1:0] t_ch_out [NPIX];
  logic [PW-1:0] t_h_in [NPIX];
  logic [PW-1:0] t_h_out [NPIX];

  // Pixel source: presents the current pixel, advances after each fetch.
  assign bus_a.data_in = src_pix[src_idx_a];
  assign bus_b.data_in = src_pix[src_idx_b];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_idx_a <= '0;
      src_idx_b <= '0;
    end else begin
      if (bus_a.data_in_valid) src_idx_a <= src_idx_a + 3'd1;
      if (bus_b.data_in_valid) src_idx_b <= src_idx_b + 3'd1;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] px(input int c0, input int c1, input int c2);
    return {8'(c2), 8'(c1), 8'(c0)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic mon(input bit sel, input logic dv, input logic ov, input logic [PW-1:0] d,
                     input logic le, input logic fe);
    exp_t  e;
    int    f;
    bit    have;
    string pn;
    pn = sel ? "b" : "a";
    if (dv) begin
      if (sel) fq_b.push_back(cyc); else fq_a.push_back(cyc);
    end
    if (!ov) begin
      chk({pn, "_idle_markers"}, 64'({le, fe}), 64'd0);
      return;
    end
    have = sel ? (exp_qb.size() > 0 && fq_b.size() > 0) : (exp_qa.size() > 0 && fq_a.size() > 0);
    if (!have) begin
      n_vec++;
      n_err++;
      $display("FAIL %s_unexpected_output: got data %0h le %0b fe %0b, expected no output", pn, d, le, fe);
      return;
    end
    if (sel) begin
      e = exp_qb.pop_front();
      f = fq_b.pop_front();
    end else begin
      e = exp_qa.pop_front();
      f = fq_a.pop_front();
    end
    chk({pn, "_pixel"}, 64'({d, le, fe}), 64'(e));
    chk({pn, "_latency"}, 64'(cyc - f), 64'd2);
    if (fe) begin
      if (sel) frames_b++; else frames_a++;
    end
  endtask

  // Monitor: decoupled from stimulus; reset discards anything in flight.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_qa.delete();
      exp_qb.delete();
      fq_a.delete();
      fq_b.delete();
    end else begin
      mon(1'b0, bus_a.data_in_valid, bus_a.data_out_valid, bus_a.data_out, bus_a.line_end, bus_a.frame_end);
      mon(1'b1, bus_b.data_in_valid, bus_b.data_out_valid, bus_b.data_out, bus_b.line_end, bus_b.frame_end);
    end
  end

  task automatic drive(input bit sel, input logic fs, input logic [1:0] md);
    if (sel) begin
      bus_b.frame_start = fs;
      bus_b.mode        = md;
    end else begin
      bus_a.frame_start = fs;
      bus_a.mode        = md;
    end
  endtask

  task automatic push_frame(input bit sel, input logic [PW-1:0] pin [NPIX], input logic [PW-1:0] pout [NPIX]);
    exp_t e;
    for (int i = 0; i < NPIX; i++) begin
      src_pix[i] = pin[i];
      e.data = pout[i];
      e.le   = ((i % W) == W - 1);
      e.fe   = (i == NPIX - 1);
      if (sel) exp_qb.push_back(e); else exp_qa.push_back(e);
    end
  endtask

  task automatic run_frame(input bit sel, input logic [1:0] md, input logic [PW-1:0] pin [NPIX],
                           input logic [PW-1:0] pout [NPIX], input bit inject);
    int           hb, fe_idx, fe_exp, fr0;
    logic [WIN-1:0] dvb, bsb, dv_exp, bs_exp;
    logic         dv, bs, fe;
    string        pn;
    pn     = sel ? "b" : "a";
    hb     = sel ? 0 : HB;
    fe_exp = 2 * W + hb + 1;
    fr0    = sel ? frames_b : frames_a;
    push_frame(sel, pin, pout);
    @(negedge clk);
    drive(sel, 1'b1, md);
    fe_idx = -1;
    for (int i = 0; i < WIN; i++) begin
      @(negedge clk);
      dv = sel ? bus_b.data_in_valid : bus_a.data_in_valid;
      bs = sel ? bus_b.busy : bus_a.busy;
      fe = sel ? bus_b.frame_end : bus_a.frame_end;
      dvb[i] = dv;
      bsb[i] = bs;
      if (fe && fe_idx < 0) fe_idx = i;
      dv_exp[i] = (i < W) || (i >= W + hb && i < 2 * W + hb);
      bs_exp[i] = (i <= fe_exp);
      // Mode is flipped after the start so any unlatched use would show.
      drive(sel, inject && (i == 2 || fe), md ^ 2'd1);
    end
    drive(sel, 1'b0, md);
    chk({pn, "_fetch_pattern"}, 64'(dvb), 64'(dv_exp));
    chk({pn, "_busy_pattern"}, 64'(bsb), 64'(bs_exp));
    chk({pn, "_frame_end_cycle"}, 64'(fe_idx), 64'(fe_exp));
    chk({pn, "_frame_count"}, 64'(sel ? frames_b : frames_a), 64'(fr0 + 1));
    chk({pn, "_queue_drained"}, 64'(sel ? exp_qb.size() : exp_qa.size()), 64'd0);
  endtask

  initial begin
    bit found;
    int fr0;
    bus_a.frame_start = 1'b0;
    bus_a.mode        = 2'd0;
    bus_b.frame_start = 1'b0;
    bus_b.mode        = 2'd0;

    t_ch     = '{px(1,2,200), px(255,255,255), px(0,0,0), px(0,255,1),
                 px(10,11,12), px(100,50,0), px(3,4,5), px(254,255,0)};
    t_ch_out = '{px(2,101,200), px(255,255,255), px(0,0,0), px(128,128,1),
                 px(11,12,12), px(75,25,0), px(4,5,5), px(255,128,0)};
    t_h_in   = '{px(10,100,0), px(20,100,1), px(255,100,2), px(0,100,3),
                 px(7,50,255), px(9,50,254), px(200,50,0), px(201,50,1)};
    t_h_out  = '{px(10,100,0), px(15,100,1), px(138,100,2), px(128,100,3),
                 px(7,50,255), px(8,50,255), px(105,50,127), px(201,50,1)};
    for (int i = 0; i < NPIX; i++) src_pix[i] = '0;

    #2 rst_n = 1'b0;
    #10;
    chk("a_reset_outputs", 64'({bus_a.data_in_valid, bus_a.data_out, bus_a.data_out_valid,
                                bus_a.line_end, bus_a.frame_end, bus_a.busy}), 64'd0);
    chk("b_reset_outputs", 64'({bus_b.data_in_valid, bus_b.data_out, bus_b.data_out_valid,
                                bus_b.line_end, bus_b.frame_end, bus_b.busy}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_frame(1'b0, 2'd0, t_ch,   t_ch,     1'b0);
    run_frame(1'b0, 2'd1, t_h_in, t_h_out,  1'b0);
    run_frame(1'b0, 2'd2, t_ch,   t_ch_out, 1'b0);
    run_frame(1'b0, 2'd0, t_h_in, t_h_in,   1'b1);

    // Abort a frame by reset at line 1, column 1.
    fr0 = frames_a;
    push_frame(1'b0, t_ch, t_ch);
    @(negedge clk);
    drive(1'b0, 1'b1, 2'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus_a.data_in_valid && src_idx_a == 3'd5) found = 1'b1;
      else @(negedge clk);
    end
    chk("a_abort_point_reached", 64'(found), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("a_async_reset_outputs", 64'({bus_a.data_in_valid, bus_a.data_out, bus_a.data_out_valid,
                                      bus_a.line_end, bus_a.frame_end, bus_a.busy}), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("a_no_frame_end_after_abort", 64'(frames_a), 64'(fr0));
    chk("a_abort_queue_cleared", 64'(exp_qa.size()), 64'd0);

    run_frame(1'b0, 2'd1, t_h_in, t_h_out, 1'b0);
    run_frame(1'b1, 2'd3, t_ch,   t_ch,    1'b0);

    repeat (5) @(negedge clk);
    chk("all_queues_empty", 64'(exp_qa.size() + exp_qb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
